// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift-add / restoring-divide
// datapath, a one-cycle sign-fix stage, and a registered single-cycle write-back pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [4:0]        cnt_r;
    logic [2:0]        op_r;
    logic [4:0]        rd_r;
    logic              neg_r;
    logic              sign_a_r;
    logic              special_r;
    logic [XLEN-1:0]   spec_val_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [XLEN-1:0]   b_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_out_r;

    logic              accept_s;
    logic              finish_s;
    logic              is_div_s;
    logic              is_rem_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   spec_val_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_sub_s;
    logic [XLEN-1:0]   hi_next_s;
    logic [XLEN-1:0]   lo_next_s;

    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quot_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_val_s;

    assign accept_s = (state_r == S_IDLE) && start && !flush;
    assign finish_s = (state_r == S_FIX) && !flush;

    // Operand decode at accept: signedness, magnitudes and the two divide special cases.
    always_comb begin
        is_div_s = funct3[2];
        is_rem_s = funct3[2] & funct3[1];
        if (funct3[2]) begin
            a_signed_s = ~funct3[0];
            b_signed_s = ~funct3[0];
        end else begin
            // MULHSU: rs1 signed, rs2 unsigned; MULHU: both unsigned
            a_signed_s = ~(funct3[1] & funct3[0]);
            b_signed_s = ~funct3[1];
        end
        a_neg_s    = a_signed_s & rs1_val[XLEN-1];
        b_neg_s    = b_signed_s & rs2_val[XLEN-1];
        a_mag_s    = a_neg_s ? (ZERO - rs1_val) : rs1_val;
        b_mag_s    = b_neg_s ? (ZERO - rs2_val) : rs2_val;
        div_zero_s = is_div_s && (rs2_val == ZERO);
        ovf_s      = is_div_s && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == ONES);
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            spec_val_s = is_rem_s ? rs1_val : ONES;
        end else if (ovf_s) begin
            spec_val_s = is_rem_s ? ZERO : MIN_NEG;
        end else begin
            spec_val_s = ZERO;
        end
    end

    // One iteration of the shared datapath: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {1'b0, ZERO});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        // the true difference is below the divisor, so the low XLEN bits are exact
        div_sub_s   = div_shift_s[XLEN-1:0] - b_r;
        if (op_r[2]) begin
            if (div_ge_s) begin
                hi_next_s = div_sub_s;
                lo_next_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_next_s = div_shift_s[XLEN-1:0];
                lo_next_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_next_s, lo_next_s} = {mul_sum_s, lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and result select used on the FIX cycle.
    always_comb begin
        prod_s     = {hi_r, lo_r};
        prod_fix_s = neg_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        quot_fix_s = neg_r ? (ZERO - lo_r) : lo_r;
        rem_fix_s  = sign_a_r ? (ZERO - hi_r) : hi_r;
        if (special_r) begin
            fix_val_s = spec_val_r;
        end else begin
            case (op_r)
                3'b000:                fix_val_s = prod_fix_s[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
                3'b100, 3'b101:        fix_val_s = quot_fix_s;
                3'b110, 3'b111:        fix_val_s = rem_fix_s;
                default:               fix_val_s = ZERO;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush always returns to IDLE and beats a same-cycle start.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = special_s ? S_FIX : S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_FIX:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Operand latch at accept and per-cycle iteration of the shared registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 5'd0;
            op_r       <= 3'd0;
            rd_r       <= 5'd0;
            neg_r      <= 1'b0;
            sign_a_r   <= 1'b0;
            special_r  <= 1'b0;
            spec_val_r <= ZERO;
            hi_r       <= ZERO;
            lo_r       <= ZERO;
            b_r        <= ZERO;
        end else if (accept_s) begin
            cnt_r      <= 5'd0;
            op_r       <= funct3;
            rd_r       <= rd_in;
            neg_r      <= a_neg_s ^ b_neg_s;
            sign_a_r   <= a_neg_s;
            special_r  <= special_s;
            spec_val_r <= spec_val_s;
            hi_r       <= ZERO;
            if (is_div_s) begin
                lo_r <= a_mag_s;
                b_r  <= b_mag_s;
            end else begin
                lo_r <= b_mag_s;
                b_r  <= a_mag_s;
            end
        end else if ((state_r == S_RUN) && !flush) begin
            cnt_r <= cnt_r + 5'd1;
            hi_r  <= hi_next_s;
            lo_r  <= lo_next_s;
        end else begin
            cnt_r <= cnt_r;
            hi_r  <= hi_r;
            lo_r  <= lo_r;
        end
    end

    // Write-back registers: one-cycle done pulse, result and rd held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r   <= 1'b0;
            result_r <= ZERO;
            rd_out_r <= 5'd0;
        end else if (finish_s) begin
            done_r   <= 1'b1;
            result_r <= fix_val_s;
            rd_out_r <= rd_r;
        end else begin
            done_r   <= 1'b0;
            result_r <= result_r;
            rd_out_r <= rd_out_r;
        end
    end

    assign busy   = (state_r != S_IDLE);
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It takes the two register-file read operands (rs1/rs2 values) plus the destination index. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU using one shared 32-step shift/add–subtract datapath. It returns a one-cycle write-back pulse (`done`, `result`, `rd_out`) that drives the register file's `we`/`wd`/`rd` write port through the write-back mux. The pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  operand A (dividend / multiplicand).
- `rs2_val`  in  32  operand B (divisor / multiplier).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high while an accepted operation is in flight.
- `done`  out  1  one-cycle pulse; `result`/`rd_out` valid this cycle (register-file write enable).
- `result`  out  32  registered result, held until the next completion.
- `rd_out`  out  5  registered destination index, held like `result`.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: 5-bit counter runs 0..31, one iteration per cycle.
  - FIX: sign correction and result select, one cycle.
- Accept: `start`=1 and `flush`=0 in IDLE. At that edge the unit latches `funct3` and `rd_in`. It also latches operand magnitudes and sign flags:
  - Signed ops take the absolute value of the signed operands.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU are unsigned.
- Multiply: 64-bit unsigned shift-add over 32 iterations. In FIX, the product is negated if the operand signs differ. MUL returns [31:0]; the MULH variants return [63:32].
- Divide: restoring division over 32 iterations, producing a 32-bit quotient and remainder. In FIX:
  - The quotient is negated if the signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
- Special cases are detected at accept. The unit skips RUN and goes straight to FIX with the result preloaded:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_val.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- FIX → IDLE. At that edge `result` and `rd_out` are registered and `done` is set for exactly one cycle.
- `start` while busy is ignored; there is no queue.
- `start` in the cycle `done` is high is accepted, giving back-to-back operation.
- `flush` in RUN or FIX: next state is IDLE, `busy`=0, and no `done` is generated. `result`/`rd_out` keep their old values.
- `flush` and `start` in the same cycle: flush wins and the request is dropped.
- `rd_out`=0 still pulses `done`; the register file discards writes to x0.
- Reset (`rst_n`=0, any time, including mid-operation):
  - State IDLE, counter 0.
  - `busy`=0, `done`=0, `result`=0, `rd_out`=0.
  - All internal datapath registers are cleared.

## Timing
- Let E0 be the accepting edge:
  - `busy`=1 from after E0 until after the edge where `done` rises.
  - Normal ops: RUN occupies edges E1..E32, FIX is exited at E33, and `done`=1 during the cycle after E33. Latency is 33 cycles.
  - Special-case divides: FIX is exited at E1 and `done`=1 after E1. Latency is 1 cycle.
- `busy` and `done` are never high in the same cycle.
- Operands and `rd_in` are sampled only at E0; later changes have no effect.
- `done` is registered; there is no combinational path from inputs to outputs.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result`=0xFFFFFFEB and `done` exactly 33 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each `done` comes with `rd_out`=`rd_in` as latched at accept.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with `done` one cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0, also at 1-cycle latency.
- Raise `flush` at counter=10 → `busy` low next cycle and no `done`; `result` unchanged. Next, assert `start` together with `flush` → dropped. Then a plain `start` → completes normally.
- Back-to-back: `start` held high continuously → a new accept in every `done` cycle and `done` pulses every 34 cycles. `start` pulsed mid-RUN is ignored.
- Assert `rst_n` low asynchronously mid-RUN → `busy`, `done`, `result` and `rd_out` are 0 immediately. After release, a new MUL 3×4 → 12.
